cpu_datapath: RTL and testbench

Execution datapath of the 8-bit accumulator CPU, directly downstream of the `machine` control sequencer. It consumes the sequencer strobes `inc_pc`, `load_acc`, `load_pc`, `load_ir`, `datactl_ena` and `halt`. It holds the program counter, the 16-bit instruction register, the accumulator and the ALU, and drives the memory address and write data. It returns `opcode` and `zero` to the sequencer, closing the control loop.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cpu_datapath_if.sv | 34 +++
 rtl/cpu_alu.sv | 26 ++
 rtl/cpu_datapath.sv | 110 +++++++++++
 tb/tb_cpu_datapath.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes and default widths.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned OP_W_DEF   = 3;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [OP_W_DEF-1:0] {
        HLT  = 3'b000,
        SKZ  = 3'b001,
        ADD  = 3'b010,
        ANDD = 3'b011,
        XORR = 3'b100,
        LDA  = 3'b101,
        STO  = 3'b110,
        JMP  = 3'b111
    } opcode_e;

endpackage

// File: rtl/cpu_datapath_if.sv
// Sequencer/memory side of the datapath: control strobes, memory bus and status back to the sequencer.
interface cpu_datapath_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
);
    logic              fetch;
    logic              inc_pc;
    logic              load_pc;
    logic              load_ir;
    logic              load_acc;
    logic              datactl_ena;
    logic              halt;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              zero;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        output fetch, inc_pc, load_pc, load_ir, load_acc, datactl_ena, halt, data_in,
        input  addr, data_out, data_oe, opcode, ir_addr, zero, instr_cnt
    );

    modport slave (
        input  fetch, inc_pc, load_pc, load_ir, load_acc, datactl_ena, halt, data_in,
        output addr, data_out, data_oe, opcode, ir_addr, zero, instr_cnt
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU of the accumulator CPU, selected by the current opcode.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] result
);

    // Non-arithmetic opcodes pass the accumulator through unchanged
    always_comb begin
        result = acc;
        case (opcode_e'(opcode))
            ADD:     result = acc + data_in;
            ANDD:    result = acc & data_in;
            XORR:    result = acc ^ data_in;
            LDA:     result = data_in;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Execution datapath of the accumulator CPU: PC, two-byte IR, ACC, ALU and memory address mux.
// Optional feature macro: CPU_DATAPATH_HALT_FREEZE_EN (halt strobe freezes all architectural state until reset).
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    cpu_datapath_if.slave  bus
);

    localparam int unsigned IR_W = 2 * DATA_W;

    logic [ADDR_W-1:0] pc;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] acc;
    logic              byte_sel;
    logic [CNT_W-1:0]  instr_cnt;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] ir_addr;
    logic              freeze;

    assign ir_addr = ir[ADDR_W-1:0];

`ifdef CPU_DATAPATH_HALT_FREEZE_EN
    logic halted;

    // Sticky halt flag; only reset releases it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (bus.halt) begin
            halted <= 1'b1;
        end
    end

    assign freeze = halted;
`else
    logic halt_unused;

    assign halt_unused = bus.halt;
    assign freeze      = 1'b0;
`endif

    // Program counter: jump target wins over sequential increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (!freeze) begin
            if (bus.load_pc) begin
                pc <= ir_addr;
            end else if (bus.inc_pc) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    // Instruction register filled high byte first; any idle cycle rewinds the byte pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir        <= '0;
            byte_sel  <= 1'b0;
            instr_cnt <= '0;
        end else if (!freeze) begin
            if (bus.load_ir) begin
                if (!byte_sel) begin
                    ir[IR_W-1:DATA_W] <= bus.data_in;
                    byte_sel          <= 1'b1;
                end else begin
                    ir[DATA_W-1:0] <= bus.data_in;
                    byte_sel       <= 1'b0;
                    instr_cnt      <= instr_cnt + CNT_W'(1);
                end
            end else begin
                byte_sel <= 1'b0;
            end
        end
    end

    // Accumulator captures the ALU result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (!freeze && bus.load_acc) begin
            acc <= alu_result;
        end
    end

    cpu_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .opcode  (bus.opcode),
        .acc     (acc),
        .data_in (bus.data_in),
        .result  (alu_result)
    );

    assign bus.addr      = bus.fetch ? pc : ir_addr;
    assign bus.data_out  = acc;
    assign bus.data_oe   = bus.datactl_ena;
    assign bus.opcode    = ir[IR_W-1 -: OP_W];
    assign bus.ir_addr   = ir_addr;
    assign bus.zero      = (acc == '0);
    assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath with hand-computed expectations.
module tb_cpu_datapath;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    cpu_datapath_if bus ();

    cpu_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr(input logic [7:0] hi, input logic [7:0] lo);
        bus.load_ir = 1'b1;
        bus.data_in = hi;
        tick();
        bus.data_in = lo;
        tick();
        bus.load_ir = 1'b0;
    endtask

    task automatic acc_op(input logic [7:0] d);
        bus.load_acc = 1'b1;
        bus.data_in  = d;
        tick();
        bus.load_acc = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        rst             = 1'b1;
        bus.fetch       = 1'b1;
        bus.inc_pc      = 1'b0;
        bus.load_pc     = 1'b0;
        bus.load_ir     = 1'b0;
        bus.load_acc    = 1'b0;
        bus.datactl_ena = 1'b0;
        bus.halt        = 1'b0;
        bus.data_in     = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_addr", 32'(bus.addr), 32'h0);
        check("rst_opcode", 32'(bus.opcode), 32'h0);
        check("rst_zero", 32'(bus.zero), 32'h1);
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_instr_cnt", 32'(bus.instr_cnt), 32'h0);
        check("rst_data_oe", 32'(bus.data_oe), 32'h0);

        // Two-cycle IR load
        bus.load_ir = 1'b1;
        bus.data_in = 8'hA1;
        tick();
        check("ir_hi_opcode", 32'(bus.opcode), 32'h5);
        check("ir_hi_addr", 32'(bus.ir_addr), 32'h0100);
        check("ir_hi_cnt", 32'(bus.instr_cnt), 32'h0);
        bus.data_in = 8'h23;
        tick();
        bus.load_ir = 1'b0;
        check("ir_lo_addr", 32'(bus.ir_addr), 32'h0123);
        check("ir_lo_opcode", 32'(bus.opcode), 32'h5);
        check("ir_lo_cnt", 32'(bus.instr_cnt), 32'h1);
        bus.fetch = 1'b0;
        #1;
        check("addr_operand", 32'(bus.addr), 32'h0123);
        bus.fetch = 1'b1;

        // LDA, ADD wrap, XORR to zero
        acc_op(8'hF0);
        check("lda_acc", 32'(bus.data_out), 32'hF0);
        check("lda_zero", 32'(bus.zero), 32'h0);
        load_instr(8'h40, 8'h00);
        check("add_cnt", 32'(bus.instr_cnt), 32'h2);
        check("add_opcode", 32'(bus.opcode), 32'h2);
        acc_op(8'h20);
        check("add_acc", 32'(bus.data_out), 32'h10);
        check("add_zero", 32'(bus.zero), 32'h0);
        load_instr(8'h80, 8'h00);
        acc_op(8'h10);
        check("xor_acc", 32'(bus.data_out), 32'h00);
        check("xor_zero", 32'(bus.zero), 32'h1);
        check("xor_cnt", 32'(bus.instr_cnt), 32'h3);

        // ANDD and STO passthrough
        load_instr(8'hA0, 8'h00);
        acc_op(8'hCF);
        load_instr(8'h60, 8'h00);
        acc_op(8'h3C);
        check("and_acc", 32'(bus.data_out), 32'h0C);
        load_instr(8'hC0, 8'h00);
        acc_op(8'hFF);
        check("sto_acc", 32'(bus.data_out), 32'h0C);
        check("sto_cnt", 32'(bus.instr_cnt), 32'h6);

        bus.datactl_ena = 1'b1;
        #1;
        check("data_oe", 32'(bus.data_oe), 32'h1);
        bus.datactl_ena = 1'b0;

        // PC wrap and load priority
        load_instr(8'hFF, 8'hFF);
        bus.load_pc = 1'b1;
        tick();
        bus.load_pc = 1'b0;
        check("pc_load_max", 32'(bus.addr), 32'h1FFF);
        bus.inc_pc = 1'b1;
        tick();
        bus.inc_pc = 1'b0;
        check("pc_wrap", 32'(bus.addr), 32'h0000);
        load_instr(8'hE4, 8'h56);
        bus.inc_pc  = 1'b1;
        bus.load_pc = 1'b1;
        tick();
        bus.inc_pc  = 1'b0;
        bus.load_pc = 1'b0;
        check("pc_priority", 32'(bus.addr), 32'h0456);

        // Low-byte load with load_pc uses the old ir_addr
        bus.load_ir = 1'b1;
        bus.data_in = 8'h20;
        tick();
        check("mix_hi_addr", 32'(bus.ir_addr), 32'h0056);
        bus.load_pc = 1'b1;
        bus.data_in = 8'h99;
        tick();
        bus.load_pc = 1'b0;
        bus.load_ir = 1'b0;
        check("mix_pc_old", 32'(bus.addr), 32'h0056);
        check("mix_ir_addr", 32'(bus.ir_addr), 32'h0099);
        check("mix_cnt", 32'(bus.instr_cnt), 32'h9);

        // Aborted fetch resync
        bus.load_ir = 1'b1;
        bus.data_in = 8'h55;
        tick();
        bus.load_ir = 1'b0;
        tick();
        load_instr(8'hE0, 8'h07);
        check("resync_addr", 32'(bus.ir_addr), 32'h0007);
        check("resync_opcode", 32'(bus.opcode), 32'h7);
        check("resync_cnt", 32'(bus.instr_cnt), 32'hA);

        // Async reset mid-operation
        load_instr(8'hA0, 8'h10);
        bus.load_acc = 1'b1;
        bus.load_pc  = 1'b1;
        bus.data_in  = 8'h3C;
        tick();
        bus.load_acc = 1'b0;
        bus.load_pc  = 1'b0;
        check("pre_rst_acc", 32'(bus.data_out), 32'h3C);
        check("pre_rst_pc", 32'(bus.addr), 32'h0010);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", 32'(bus.addr), 32'h0);
        check("arst_acc", 32'(bus.data_out), 32'h0);
        check("arst_zero", 32'(bus.zero), 32'h1);
        check("arst_cnt", 32'(bus.instr_cnt), 32'h0);
        #1;
        rst = 1'b0;

        // Fetch after reset starts from the high byte
        bus.load_ir = 1'b1;
        bus.data_in = 8'h40;
        tick();
        check("post_rst_opcode", 32'(bus.opcode), 32'h2);
        check("post_rst_cnt0", 32'(bus.instr_cnt), 32'h0);
        bus.data_in = 8'h00;
        tick();
        bus.load_ir = 1'b0;
        check("post_rst_cnt1", 32'(bus.instr_cnt), 32'h1);

        // Halt strobe followed by increments
        bus.halt = 1'b1;
        tick();
        bus.halt   = 1'b0;
        bus.inc_pc = 1'b1;
        tick();
        tick();
        tick();
        bus.inc_pc = 1'b0;
        acc_op(8'h05);
        load_instr(8'hA0, 8'h00);
`ifdef CPU_DATAPATH_HALT_FREEZE_EN
        check("halt_pc", 32'(bus.addr), 32'h0);
        check("halt_acc", 32'(bus.data_out), 32'h0);
        check("halt_cnt", 32'(bus.instr_cnt), 32'h1);
`else
        check("halt_pc", 32'(bus.addr), 32'h3);
        check("halt_acc", 32'(bus.data_out), 32'h5);
        check("halt_cnt", 32'(bus.instr_cnt), 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
